// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - integer issue queue with wakeup and oldest-ready select
//
// Holds up to DEPTH micro-ops from dispatch. Each entry sleeps on its two
// sources until a writeback broadcast matches them. Every cycle the oldest
// entry with both sources ready is offered to the integer execution pipe.
//
// Ports:
//   clock, reset_n                    clock, asynchronous active-low reset
//   intisq_can_enq / intisq2disp_enq_ready   at least one free entry
//   disp2intisq_enq_valid, *_enq_data, *_enq_condition, bt2disp_* busy bits
//   wb0/wb1_valid, wb0/wb1_prd        writeback tag broadcasts
//   flush_valid                       kill all entries next edge
//   intisq2exu_issue_valid/data/condition, exu2intisq_issue_ready
//   intisq_count                      occupied entries
//
// Optional feature macro: INTISQ_ENQ_BYPASS_EN (enqueue-time wakeup bypass).
module int_issue_queue #(
  parameter int DATA_WIDTH      = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int DEPTH           = 8,
  parameter int INDEX_WIDTH     = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic                       intisq_can_enq,
  output logic                       intisq2disp_enq_ready,
  input  logic                       disp2intisq_enq_valid,
  input  logic [DATA_WIDTH-1:0]      disp2intisq_instr0_enq_data,
  input  logic [CONDITION_WIDTH-1:0] disp2intisq_instr0_enq_condition,
  input  logic                       bt2disp_instr0rs1_busy,
  input  logic                       bt2disp_instr0rs2_busy,
  input  logic                       wb0_valid,
  input  logic                       wb1_valid,
  input  logic [5:0]                 wb0_prd,
  input  logic [5:0]                 wb1_prd,
  input  logic                       flush_valid,
  output logic                       intisq2exu_issue_valid,
  input  logic                       exu2intisq_issue_ready,
  output logic [DATA_WIDTH-1:0]      intisq2exu_issue_data,
  output logic [CONDITION_WIDTH-1:0] intisq2exu_issue_condition,
  output logic [INDEX_WIDTH-1:0]     intisq_count
);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0]           rdy1_q, rdy1_d;
  logic [DEPTH-1:0]           rdy2_q, rdy2_d;
  logic [DATA_WIDTH-1:0]      data_q [DEPTH];
  logic [DATA_WIDTH-1:0]      data_d [DEPTH];
  logic [CONDITION_WIDTH-1:0] cond_q [DEPTH];
  logic [CONDITION_WIDTH-1:0] cond_d [DEPTH];
  // age_q[i][j] set: entry i is older than entry j
  logic [DEPTH-1:0]           age_q [DEPTH];
  logic [DEPTH-1:0]           age_d [DEPTH];
  logic [INDEX_WIDTH-1:0]     count_q, count_d;

  logic [DEPTH-1:0] eligible, winner_oh, alloc_oh;
  logic             older_elig, alloc_found;
  logic             enq_fire, issue_fire;
  logic             enq_rdy1, enq_rdy2;
  logic [5:0]       enq_prs1, enq_prs2;

  assign intisq_can_enq        = (count_q != INDEX_WIDTH'(DEPTH));
  assign intisq2disp_enq_ready = intisq_can_enq;
  assign intisq_count          = count_q;

  assign enq_prs1   = disp2intisq_instr0_enq_data[116:111];
  assign enq_prs2   = disp2intisq_instr0_enq_data[110:105];
  assign enq_fire   = disp2intisq_enq_valid && intisq_can_enq && !flush_valid;
  assign issue_fire = intisq2exu_issue_valid && exu2intisq_issue_ready;

  // Oldest-ready select: an eligible entry wins when no other eligible
  // entry is marked older than it.
  always_comb begin
    eligible   = valid_q & rdy1_q & rdy2_q;
    winner_oh  = '0;
    older_elig = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older_elig = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && age_q[j][i]) older_elig = 1'b1;
      end
      winner_oh[i] = eligible[i] && !older_elig;
    end
    intisq2exu_issue_valid     = |eligible;
    intisq2exu_issue_data      = '0;
    intisq2exu_issue_condition = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (winner_oh[i]) begin
        intisq2exu_issue_data      = intisq2exu_issue_data | data_q[i];
        intisq2exu_issue_condition = intisq2exu_issue_condition | cond_q[i];
      end
    end
  end

  // Lowest free slot, taken from pre-edge valids so a slot released by
  // this cycle's issue is not reused until the next cycle.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    data_d  = data_q;
    cond_d  = cond_q;
    age_d   = age_q;
    count_d = count_q;

    enq_rdy1 = !disp2intisq_instr0_enq_data[104] || (enq_prs1 == 6'd0) ||
               !bt2disp_instr0rs1_busy;
    enq_rdy2 = !disp2intisq_instr0_enq_data[103] || (enq_prs2 == 6'd0) ||
               !bt2disp_instr0rs2_busy;
`ifdef INTISQ_ENQ_BYPASS_EN
    // Catch a writeback that lands in the same cycle as a stale busy read.
    enq_rdy1 = enq_rdy1 || (wb0_valid && enq_prs1 == wb0_prd) ||
                           (wb1_valid && enq_prs1 == wb1_prd);
    enq_rdy2 = enq_rdy2 || (wb0_valid && enq_prs2 == wb0_prd) ||
                           (wb1_valid && enq_prs2 == wb1_prd);
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if ((wb0_valid && data_q[i][116:111] == wb0_prd) ||
            (wb1_valid && data_q[i][116:111] == wb1_prd)) rdy1_d[i] = 1'b1;
        if ((wb0_valid && data_q[i][110:105] == wb0_prd) ||
            (wb1_valid && data_q[i][110:105] == wb1_prd)) rdy2_d[i] = 1'b1;
      end
    end

    if (flush_valid) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      if (issue_fire) valid_d = valid_d & ~winner_oh;
      if (enq_fire) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (alloc_oh[k]) begin
            valid_d[k] = 1'b1;
            rdy1_d[k]  = enq_rdy1;
            rdy2_d[k]  = enq_rdy2;
            data_d[k]  = disp2intisq_instr0_enq_data;
            cond_d[k]  = disp2intisq_instr0_enq_condition;
            age_d[k]   = '0;
            for (int j = 0; j < DEPTH; j++) begin
              if (valid_q[j] && j != k) age_d[j][k] = 1'b1;
            end
          end
        end
      end
      count_d = count_q + INDEX_WIDTH'(enq_fire) - INDEX_WIDTH'(issue_fire);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cond_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
      data_q  <= data_d;
      cond_q  <= cond_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - scoreboard bench for int_issue_queue
module tb_int_issue_queue;

  localparam int DW    = 248;
  localparam int CW    = 2;
  localparam int DEPTH = 8;
  localparam int IW    = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          can_enq, enq_ready;
  logic          enq_valid = 1'b0;
  logic [DW-1:0] enq_data = '0;
  logic [CW-1:0] enq_cond = '0;
  logic          busy1 = 1'b0, busy2 = 1'b0;
  logic          w0v = 1'b0, w1v = 1'b0;
  logic [5:0]    w0p = '0, w1p = '0;
  logic          flush = 1'b0;
  logic          iss_valid;
  logic          iss_ready = 1'b0;
  logic [DW-1:0] iss_data;
  logic [CW-1:0] iss_cond;
  logic [IW-1:0] count;

  int n_cmp = 0;
  int n_fail = 0;

  int_issue_queue #(.DATA_WIDTH(DW), .CONDITION_WIDTH(CW), .DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset_n(reset_n),
    .intisq_can_enq(can_enq), .intisq2disp_enq_ready(enq_ready),
    .disp2intisq_enq_valid(enq_valid),
    .disp2intisq_instr0_enq_data(enq_data),
    .disp2intisq_instr0_enq_condition(enq_cond),
    .bt2disp_instr0rs1_busy(busy1), .bt2disp_instr0rs2_busy(busy2),
    .wb0_valid(w0v), .wb1_valid(w1v), .wb0_prd(w0p), .wb1_prd(w1p),
    .flush_valid(flush),
    .intisq2exu_issue_valid(iss_valid), .exu2intisq_issue_ready(iss_ready),
    .intisq2exu_issue_data(iss_data), .intisq2exu_issue_condition(iss_cond),
    .intisq_count(count)
  );

  always #5 clock = ~clock;

  // Reference model: program-ordered list of held micro-ops.
  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] cond;
    bit            r1, r2;
  } ent_t;

  typedef struct {
    bit            iv;
    logic [DW-1:0] data;
    logic [CW-1:0] cond;
    int            cnt;
    bit            can;
  } exp_t;

  ent_t mq[$];
  exp_t expq[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [5:0] p1, input logic [5:0] p2,
                                       input bit s1, input bit s2);
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
    t[116:111] = p1;
    t[110:105] = p2;
    t[104]     = s1;
    t[103]     = s2;
    return t[DW-1:0];
  endfunction

  // Drives one cycle starting just after a rising edge, records what the
  // outputs must show this cycle, then advances the model across the edge.
  task automatic step(input bit enq, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit b1, input bit b2,
                      input bit v0, input logic [5:0] p0, input bit v1, input logic [5:0] p1,
                      input bit fl, input bit ir);
    exp_t e;
    int   win;
    bit   can;
    ent_t n;
    logic [5:0] q1, q2;
    enq_valid = enq; enq_data = d; enq_cond = c; busy1 = b1; busy2 = b2;
    w0v = v0; w0p = p0; w1v = v1; w1p = p1; flush = fl; iss_ready = ir;

    win = -1;
    foreach (mq[i]) if (win < 0 && mq[i].r1 && mq[i].r2) win = i;
    e.iv   = (win >= 0);
    e.data = (win >= 0) ? mq[win].data : '0;
    e.cond = (win >= 0) ? mq[win].cond : '0;
    e.cnt  = mq.size();
    e.can  = (mq.size() < DEPTH);
    expq.push_back(e);

    can = (mq.size() < DEPTH);
    if (fl) begin
      mq.delete();
    end else begin
      foreach (mq[i]) begin
        q1 = mq[i].data[116:111];
        q2 = mq[i].data[110:105];
        if ((v0 && q1 == p0) || (v1 && q1 == p1)) mq[i].r1 = 1;
        if ((v0 && q2 == p0) || (v1 && q2 == p1)) mq[i].r2 = 1;
      end
      if (win >= 0 && ir) mq.delete(win);
      if (enq && can) begin
        q1 = d[116:111];
        q2 = d[110:105];
        n.data = d;
        n.cond = c;
        n.r1 = !d[104] || q1 == 0 || !b1;
        n.r2 = !d[103] || q2 == 0 || !b2;
`ifdef INTISQ_ENQ_BYPASS_EN
        if ((v0 && q1 == p0) || (v1 && q1 == p1)) n.r1 = 1;
        if ((v0 && q2 == p0) || (v1 && q2 == p1)) n.r2 = 1;
`endif
        mq.push_back(n);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit ir);
    step(0, '0, '0, 0, 0, 0, '0, 0, '0, 0, ir);
  endtask

  task automatic enq_op(input logic [DW-1:0] d, input bit b1, input bit b2, input bit ir);
    step(1, d, CW'($urandom), b1, b2, 0, '0, 0, '0, 0, ir);
  endtask

  // Monitor: compares every recorded cycle at the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("issue_valid", 256'(iss_valid), 256'(e.iv));
      chk("issue_data", 256'(iss_data), 256'(e.data));
      chk("issue_cond", 256'(iss_cond), 256'(e.cond));
      chk("count", 256'(count), 256'(e.cnt));
      chk("can_enq", 256'(can_enq), 256'(e.can));
      chk("enq_ready", 256'(enq_ready), 256'(e.can));
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_can_enq", 256'(can_enq), 256'(1));
    chk("rst_enq_ready", 256'(enq_ready), 256'(1));
    chk("rst_issue_valid", 256'(iss_valid), 256'(0));
    chk("rst_issue_data", 256'(iss_data), 256'(0));
    chk("rst_issue_cond", 256'(iss_cond), 256'(0));
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Sleeping source woken by wb0.
    enq_op(mk(6'd5, 6'd3, 1, 0), 1, 1, 1);
    idle(1);
    step(0, '0, '0, 0, 0, 1, 6'd5, 0, '0, 0, 1);
    idle(1);
    idle(1);

    // Fill, overfill, then drain in order.
    for (int i = 0; i < 9; i++) enq_op(mk(6'(i), 6'(i + 1), 1, 1), 0, 0, 0);
    chk("full_count", 256'(count), 256'(DEPTH));
    chk("full_can_enq", 256'(can_enq), 256'(0));
    repeat (9) idle(1);

    // Younger ready entry bypasses older sleeping one.
    enq_op(mk(6'd7, 6'd0, 1, 1), 1, 0, 0);
    enq_op(mk(6'd1, 6'd2, 1, 1), 0, 0, 1);
    idle(1);
    step(0, '0, '0, 0, 0, 0, '0, 1, 6'd7, 0, 1);
    repeat (2) idle(1);

    // Full queue with simultaneous issue and enqueue.
    for (int i = 0; i < 8; i++) enq_op(mk(6'd0, 6'd0, 0, 0), 0, 0, 0);
    enq_op(mk(6'd0, 6'd0, 0, 0), 0, 0, 1);
    chk("full_issue_count", 256'(count), 256'(DEPTH - 1));
    enq_op(mk(6'd0, 6'd0, 0, 0), 0, 0, 0);
    chk("refill_count", 256'(count), 256'(DEPTH));
    repeat (9) idle(1);

    // Writeback coinciding with enqueue of a busy source.
    step(1, mk(6'd9, 6'd0, 1, 0), 2'd1, 1, 0, 1, 6'd9, 0, '0, 0, 1);
    repeat (2) idle(1);
    step(0, '0, '0, 0, 0, 1, 6'd9, 0, '0, 0, 1);
    repeat (2) idle(1);

    // Flush beats a same-cycle enqueue.
    for (int i = 0; i < 4; i++) enq_op(mk(6'd0, 6'd0, 0, 0), 0, 0, 0);
    step(1, mk(6'd0, 6'd0, 0, 0), 2'd2, 0, 0, 0, '0, 0, '0, 1, 0);
    chk("flush_count", 256'(count), 256'(0));
    chk("flush_issue_valid", 256'(iss_valid), 256'(0));
    chk("flush_can_enq", 256'(can_enq), 256'(1));
    idle(1);

    // Randomized traffic on a small tag space so wakeups collide often.
    for (int t = 0; t < 600; t++) begin
      step($urandom_range(0, 9) < 6,
           mk(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 1'($urandom), 1'($urandom)),
           CW'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, 6'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, 6'($urandom_range(0, 7)),
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7);
    end

    // Reset asserted mid-operation clears state without waiting for an edge.
    for (int i = 0; i < 3; i++) enq_op(mk(6'd0, 6'd0, 0, 0), 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 256'(count), 256'(0));
    chk("async_rst_issue_valid", 256'(iss_valid), 256'(0));
    chk("async_rst_can_enq", 256'(can_enq), 256'(1));
    mq.delete();
    enq_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    enq_op(mk(6'd0, 6'd0, 0, 0), 0, 0, 0);
    repeat (2) idle(1);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", 256'(expq.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
